// File: rtl/ltc2333_pkg.sv
// Shared definitions for the LTC2333 read/write engines: frame layout and FSM states.
package ltc2333_pkg;

  localparam int unsigned FRAME_BITS  = 24;
  localparam int unsigned RESULT_BITS = 18;
  localparam int unsigned NCHAN       = 8;

  // MSB-first frame as shifted in from SDO
  typedef struct packed {
    logic [RESULT_BITS-1:0] result;
    logic [2:0]             chan_id;
    logic [2:0]             softspan;
  } ltc2333_frame_t;

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_t;

endpackage

// File: rtl/ltc2333_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module ltc2333_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ltc2333_read.sv
// LTC2333 SDO deserialiser: captures 24-bit frames inside the delayed SCKI window,
// tags them with a conversion sequence number and queues them for a valid/ready sink.
module ltc2333_read
  import ltc2333_pkg::*;
#(
  parameter int unsigned CAPTURE_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter bit          DISCARD_FIRST   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             capture_en,
  input  logic [1:0]       sdo_pair,
  input  logic [NCHAN-1:0] active_channels,
  input  logic             clear_flags,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             frame_err,
  output logic             id_err,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0]  CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0]  CNT_LAST = 5'(FRAME_BITS - 2);

  logic cap_d;

  generate
    if (CAPTURE_LATENCY == 0) begin : g_nodly
      assign cap_d = capture_en;
    end else begin : g_dly
      logic [CAPTURE_LATENCY-1:0] cap_sr;
      always_ff @(posedge clk) begin
        if (reset) cap_sr <= '0;
        else       cap_sr <= (cap_sr << 1) | CAPTURE_LATENCY'(capture_en);
      end
      assign cap_d = cap_sr[CAPTURE_LATENCY-1];
    end
  endgenerate

  state_t                state;
  logic                  cap_prev;
  logic [FRAME_BITS-3:0] shreg;
  logic [4:0]            bit_cnt;
  logic [7:0]            conv_seq;
  logic                  discard;
  logic                  start_pend;

  ltc2333_frame_t        frame;
  logic                  complete;
  logic                  keep;
  logic                  pop;
  logic                  drop;
  logic                  bad_id;
  logic                  ferr_evt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [31:0]           fifo_data;

  // Frame completes on the cycle that shifts in the last pair, so push uses the next shreg value
  assign frame    = {shreg, sdo_pair};
  assign complete = (state == CAPTURE) && cap_d && (bit_cnt == CNT_LAST);
  assign keep     = complete && !discard;
  assign pop      = m_tvalid && m_tready;
  assign drop     = keep && fifo_full && !pop;
  assign bad_id   = keep && !active_channels[frame.chan_id];
  assign ferr_evt = (state == CAPTURE) && !cap_d && (bit_cnt != '0) && (bit_cnt != CNT_FULL);

  ltc2333_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (keep),
    .push_data ({conv_seq, frame}),
    .pop       (m_tready),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = m_tvalid ? fifo_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cap_prev   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      conv_seq   <= '0;
      discard    <= DISCARD_FIRST;
      start_pend <= 1'b0;
      frame_err  <= 1'b0;
      id_err     <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      cap_prev <= cap_d;
      case (state)
        IDLE: begin
          // A start seen mid-capture is parked and applied here, before the next window opens
          if (start || start_pend) begin
            conv_seq   <= '0;
            discard    <= DISCARD_FIRST;
            start_pend <= 1'b0;
          end
          if (cap_d && !cap_prev) begin
            state   <= CAPTURE;
            shreg   <= (FRAME_BITS-2)'(sdo_pair);
            bit_cnt <= 5'd2;
          end
        end
        CAPTURE: begin
          if (start) start_pend <= 1'b1;
          if (cap_d) begin
            shreg   <= frame[FRAME_BITS-3:0];
            bit_cnt <= (bit_cnt == CNT_FULL) ? 5'd2 : bit_cnt + 5'd2;
          end else begin
            state   <= IDLE;
            bit_cnt <= '0;
            if (discard) discard  <= 1'b0;
            else         conv_seq <= conv_seq + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      frame_err <= ferr_evt | (frame_err & ~clear_flags);
      id_err    <= bad_id   | (id_err & ~clear_flags);
      overflow  <= drop     | (overflow & ~clear_flags);
      if (clear_flags)                   drop_cnt <= drop ? 16'd1 : 16'd0;
      else if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
    end
  end

  a_fifo_count : assert property (@(posedge clk) disable iff (reset)
    (fifo_count <= CNT_W'(FIFO_DEPTH)) && (fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ltc2333_read.sv
// Randomised bench for ltc2333_read against a conversion/frame-level queue model.
module tb_ltc2333_read;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        capture_en = 1'b0;
  logic [1:0]  sdo_pair;
  logic [7:0]  active_channels = 8'hFF;
  logic        clear_flags = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        frame_err;
  logic        id_err;
  logic        overflow;
  logic [15:0] drop_cnt;

  ltc2333_read #(
    .CAPTURE_LATENCY (LAT),
    .FIFO_DEPTH      (DEPTH),
    .DISCARD_FIRST   (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .capture_en      (capture_en),
    .sdo_pair        (sdo_pair),
    .active_channels (active_channels),
    .clear_flags     (clear_flags),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .frame_err       (frame_err),
    .id_err          (id_err),
    .overflow        (overflow),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  // ADC round trip: SDO data trails the enable by LAT (=2) clocks
  logic [1:0] pair_src = 2'b00;
  logic [1:0] p1 = 2'b00;
  logic [1:0] p2 = 2'b00;
  int         cyc = 0;
  always @(posedge clk) begin
    p1  <= pair_src;
    p2  <= p1;
    cyc <= cyc + 1;
  end
  assign sdo_pair = p2;

  typedef struct {
    int          due;
    bit          is_ferr;
    logic [31:0] word;
    bit          idbad;
  } ev_t;

  ev_t         sched[$];
  logic [31:0] expq[$];
  logic [23:0] frm[$];
  bit          m_ferr, m_id, m_ovf, m_disc;
  logic [15:0] m_drop;
  logic [7:0]  m_seq;
  bit          rnd_rdy = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    expq.delete();
    sched.delete();
    m_ferr = 0; m_id = 0; m_ovf = 0; m_drop = '0;
    m_seq = '0; m_disc = 1'b1;
  endtask

  function automatic logic [23:0] mkframe(input int ch);
    logic [31:0] r;
    r = $urandom();
    return {r[17:0], 3'(ch), r[22:20]};
  endfunction

  // Each negedge models what the coming posedge does: clear, pop, then due frame events
  always @(negedge clk) begin : model
    ev_t ev;
    if (!reset) begin
      chk("tvalid", 32'(m_tvalid), 32'(expq.size() != 0));
      if (clear_flags) begin
        m_ferr = 0; m_id = 0; m_ovf = 0; m_drop = '0;
      end
      if (m_tvalid && m_tready) begin
        chk("beat_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) chk("beat", m_tdata, expq.pop_front());
      end
      while (sched.size() != 0 && sched[0].due <= cyc + 1) begin
        ev = sched.pop_front();
        if (ev.is_ferr) m_ferr = 1;
        else begin
          if (ev.idbad) m_id = 1;
          if (expq.size() < DEPTH) expq.push_back(ev.word);
          else begin
            m_ovf = 1;
            if (m_drop != 16'hFFFF) m_drop++;
          end
        end
      end
    end
  end

  // Serialises frm[] as one conversion of npairs SCKI cycles
  task automatic send_conv(input int npairs);
    logic [23:0] f;
    int k;
    for (int p = 0; p < npairs; p++) begin
      f = frm[p / 12];
      k = p % 12;
      capture_en = 1'b1;
      pair_src   = f[23 - 2*k -: 2];
      if (rnd_rdy) m_tready = 1'($urandom_range(0, 1));
      if (k == 11 && !m_disc)
        sched.push_back('{cyc + 3, 1'b0, {m_seq, f}, !active_channels[f[5:3]]});
      tick();
    end
    capture_en = 1'b0;
    pair_src   = 2'b00;
    if (npairs % 12 != 0) sched.push_back('{cyc + 3, 1'b1, 32'h0, 1'b0});
    if (m_disc) m_disc = 0;
    else        m_seq++;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (n < 300 && (sched.size() != 0 || (m_tready && expq.size() != 0))) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk("settle_timeout", 32'(n >= 300), 32'd0);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "_id_err"},    32'(id_err),    32'(m_id));
    chk({tag, "_overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, "_drop_cnt"},  32'(drop_cnt),  32'(m_drop));
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_seq = '0;
    m_disc = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nf, extra;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    check_flags("rst");

    // discard of first conversion, then conv_seq 0,0,1,1
    for (int c = 0; c < 3; c++) begin
      frm.delete();
      for (int i = 0; i < 2; i++) frm.push_back(mkframe(i));
      send_conv(24);
      repeat (3) tick();
    end
    settle();
    check_flags("seq");

    // known frame after a start-triggered discard
    pulse_start();
    frm = '{mkframe(5)};
    send_conv(12);
    repeat (3) tick();
    frm = '{24'hABCDE1};
    send_conv(12);
    settle();
    chk("single_seq", 32'(m_seq), 32'd1);
    check_flags("single");

    // partial frame
    frm = '{mkframe(2)};
    send_conv(7);
    settle();
    check_flags("partial");
    pulse_clear();
    check_flags("partial_clr");

    // channel id outside mask
    active_channels = 8'h05;
    frm = '{mkframe(1)};
    send_conv(12);
    settle();
    check_flags("idchk");
    pulse_clear();
    active_channels = 8'hFF;

    // random traffic with random ready and masks
    rnd_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      active_channels = 8'($urandom());
      nf = $urandom_range(1, 3);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : 0;
      frm.delete();
      for (int i = 0; i <= nf; i++) frm.push_back(mkframe($urandom_range(0, 7)));
      send_conv(nf * 12 + extra);
      repeat (3) tick();
    end
    rnd_rdy = 1'b0;
    m_tready = 1'b1;
    settle();
    check_flags("random");
    pulse_clear();
    active_channels = 8'hFF;

    // overflow: 6 frames into 4 entries
    m_tready = 1'b0;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(mkframe(i));
    send_conv(72);
    settle();
    check_flags("ovf");
    chk("ovf_drop_const", 32'(drop_cnt), 32'd2);

    // push into full FIFO with a pop on the same cycle
    frm = '{mkframe(6)};
    send_conv(12);
    tick();
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    settle();
    check_flags("ovf_pop");

    // clear_flags on the same cycle as an overflow drop
    frm = '{mkframe(7)};
    send_conv(12);
    tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    settle();
    check_flags("ovf_clr");
    m_tready = 1'b1;
    settle();

    // reset mid-frame with two entries queued
    pulse_clear();
    m_tready = 1'b0;
    frm = '{mkframe(0), mkframe(1)};
    send_conv(24);
    repeat (3) tick();
    frm = '{mkframe(3)};
    send_conv(7);
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check_flags("midrst");
    m_tready = 1'b1;
    frm = '{mkframe(4)};
    send_conv(12);
    repeat (3) tick();
    frm = '{mkframe(2)};
    send_conv(12);
    settle();
    check_flags("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
